// File: rtl/gps_nmea_framer.sv
// ============================================================================
//  Module   : gps_nmea_framer
//  Frames "$<payload>*HH\r\n" NMEA sentences from a UART byte stream, checks
//  the XOR checksum and publishes verified payloads through a ping-pong buffer.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module gps_nmea_framer #(
    parameter int MAX_LEN = 80,
    parameter int ADDR_W  = 7,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              sent_ready,
    output logic [ADDR_W-1:0] sent_len,
    input  logic              sent_ack,
    output logic [CNT_W-1:0]  err_cksum,
    output logic [CNT_W-1:0]  err_frame,
    output logic [CNT_W-1:0]  err_overflow,
    output logic [CNT_W-1:0]  drop_count
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_BODY   = 3'd1;
    localparam logic [2:0] c_ST_CK_HI  = 3'd2;
    localparam logic [2:0] c_ST_CK_LO  = 3'd3;
    localparam logic [2:0] c_ST_EOL_CR = 3'd4;
    localparam logic [2:0] c_ST_EOL_LF = 3'd5;

    localparam logic [7:0] c_DOLLAR = 8'h24;
    localparam logic [7:0] c_STAR   = 8'h2A;
    localparam logic [7:0] c_CR     = 8'h0D;
    localparam logic [7:0] c_LF     = 8'h0A;
    localparam logic [ADDR_W-1:0] c_MAX_LEN = ADDR_W'(MAX_LEN);
    localparam logic [CNT_W-1:0]  c_CNT_MAX = '1;

    logic [2:0]        r_state;
    logic [2:0]        w_state_next;
    logic [ADDR_W-1:0] r_len;
    logic [7:0]        r_cksum;
    logic [3:0]        r_ck_hi;
    logic [3:0]        r_ck_lo;
    logic              r_wr_bank;
    logic              r_rd_bank;
    logic [7:0]        r_mem [0:1][0:MAX_LEN-1];

    logic       w_hex_ok;
    logic [3:0] w_hex_val;
    logic       w_eol;
    logic       w_resync, w_store, w_latch_hi, w_latch_lo, w_complete;
    logic       w_inc_frame, w_inc_ovf;
    logic       w_match, w_publish, w_drop, w_bad;

    always_comb begin
        w_hex_ok  = 1'b0;
        w_hex_val = 4'h0;
        if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
            w_hex_ok  = 1'b1;
            w_hex_val = rx_data[3:0];
        end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                     (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
            w_hex_ok  = 1'b1;
            w_hex_val = rx_data[3:0] + 4'd9;
        end
    end

    assign w_eol = (rx_data == c_CR) || (rx_data == c_LF);

    always_ff @(posedge clk) begin
        if (reset) r_state <= c_ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (rx_valid) begin
            if (rx_data == c_DOLLAR) begin
                w_state_next = c_ST_BODY;
            end else begin
                case (r_state)
                    c_ST_IDLE:   w_state_next = c_ST_IDLE;
                    c_ST_BODY: begin
                        if (rx_data == c_STAR)       w_state_next = c_ST_CK_HI;
                        else if (w_eol)              w_state_next = c_ST_IDLE;
                        else if (r_len == c_MAX_LEN) w_state_next = c_ST_IDLE;
                    end
                    c_ST_CK_HI:  w_state_next = w_hex_ok ? c_ST_CK_LO : c_ST_IDLE;
                    c_ST_CK_LO:  w_state_next = w_hex_ok ? c_ST_EOL_CR : c_ST_IDLE;
                    c_ST_EOL_CR: w_state_next = (rx_data == c_CR) ? c_ST_EOL_LF : c_ST_IDLE;
                    default:     w_state_next = c_ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        w_resync    = 1'b0;
        w_store     = 1'b0;
        w_latch_hi  = 1'b0;
        w_latch_lo  = 1'b0;
        w_complete  = 1'b0;
        w_inc_frame = 1'b0;
        w_inc_ovf   = 1'b0;
        if (rx_valid) begin
            if (rx_data == c_DOLLAR) begin
                w_resync = 1'b1;
            end else begin
                case (r_state)
                    c_ST_BODY: begin
                        if (rx_data == c_STAR)       w_store     = 1'b0;
                        else if (w_eol)              w_inc_frame = 1'b1;
                        else if (r_len == c_MAX_LEN) w_inc_ovf   = 1'b1;
                        else                         w_store     = 1'b1;
                    end
                    c_ST_CK_HI: begin
                        w_latch_hi  = w_hex_ok;
                        w_inc_frame = !w_hex_ok;
                    end
                    c_ST_CK_LO: begin
                        w_latch_lo  = w_hex_ok;
                        w_inc_frame = !w_hex_ok;
                    end
                    c_ST_EOL_CR: w_inc_frame = (rx_data != c_CR);
                    c_ST_EOL_LF: begin
                        w_complete  = (rx_data == c_LF);
                        w_inc_frame = (rx_data != c_LF);
                    end
                    default: w_store = 1'b0;
                endcase
            end
        end
    end

    // An ack on the completion cycle frees the read bank before the new publish.
    assign w_match   = ({r_ck_hi, r_ck_lo} == r_cksum);
    assign w_publish = w_complete && w_match && (!sent_ready || sent_ack);
    assign w_drop    = w_complete && w_match && sent_ready && !sent_ack;
    assign w_bad     = w_complete && !w_match;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_len        <= '0;
            r_cksum      <= 8'h00;
            r_ck_hi      <= 4'h0;
            r_ck_lo      <= 4'h0;
            r_wr_bank    <= 1'b0;
            r_rd_bank    <= 1'b0;
            sent_len     <= '0;
            sent_ready   <= 1'b0;
            err_cksum    <= '0;
            err_frame    <= '0;
            err_overflow <= '0;
            drop_count   <= '0;
        end else begin
            if (w_resync) begin
                r_len   <= '0;
                r_cksum <= 8'h00;
            end
            if (w_store) begin
                r_len   <= r_len + 1'b1;
                r_cksum <= r_cksum ^ rx_data;
            end
            if (w_latch_hi) r_ck_hi <= w_hex_val;
            if (w_latch_lo) r_ck_lo <= w_hex_val;
            if (sent_ack) sent_ready <= 1'b0;
            if (w_publish) begin
                r_rd_bank  <= r_wr_bank;
                r_wr_bank  <= ~r_wr_bank;
                sent_len   <= r_len;
                sent_ready <= 1'b1;
            end
            if (w_bad && err_cksum != c_CNT_MAX)          err_cksum    <= err_cksum + 1'b1;
            if (w_inc_frame && err_frame != c_CNT_MAX)    err_frame    <= err_frame + 1'b1;
            if (w_inc_ovf && err_overflow != c_CNT_MAX)   err_overflow <= err_overflow + 1'b1;
            if (w_drop && drop_count != c_CNT_MAX)        drop_count   <= drop_count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_store) r_mem[r_wr_bank][r_len] <= rx_data;
    end

    always_ff @(posedge clk) begin
        if (reset)                              rd_data <= 8'h00;
        else if (sent_ready && rd_addr < sent_len) rd_data <= r_mem[r_rd_bank][rd_addr];
        else                                    rd_data <= 8'h00;
    end

endmodule

`default_nettype wire

// File: tb/tb_gps_nmea_framer.sv
// ============================================================================
//  Module   : tb_gps_nmea_framer
//  Self-checking bench for gps_nmea_framer against a queue-based sentence model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_gps_nmea_framer;

    localparam int MAX_LEN = 80;
    localparam int ADDR_W  = 7;
    localparam int CNT_W   = 16;
    localparam int VEC_W   = 1 + ADDR_W + 4 * CNT_W;

    logic              clk;
    logic              reset;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              sent_ready;
    logic [ADDR_W-1:0] sent_len;
    logic              sent_ack;
    logic [CNT_W-1:0]  err_cksum;
    logic [CNT_W-1:0]  err_frame;
    logic [CNT_W-1:0]  err_overflow;
    logic [CNT_W-1:0]  drop_count;
    logic [VEC_W-1:0]  act;

    gps_nmea_framer #(.MAX_LEN(MAX_LEN), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rd_addr(rd_addr), .rd_data(rd_data), .sent_ready(sent_ready),
        .sent_len(sent_len), .sent_ack(sent_ack), .err_cksum(err_cksum),
        .err_frame(err_frame), .err_overflow(err_overflow), .drop_count(drop_count)
    );

    assign act = {sent_ready, sent_len, err_cksum, err_frame, err_overflow, drop_count};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: sentence text collected in queues, decided by position after '*'.
    bit         m_active, m_star, m_ready;
    logic [7:0] m_cur[$];
    logic [7:0] m_tail[$];
    logic [7:0] m_pub[$];
    int         m_len, m_cks, m_frm, m_ovf, m_drp;

    function automatic int sat(input int v);
        return (v >= 65535) ? v : v + 1;
    endfunction

    function automatic bit is_hex(input logic [7:0] b);
        return (b >= "0" && b <= "9") || (b >= "A" && b <= "F") || (b >= "a" && b <= "f");
    endfunction

    function automatic logic [3:0] hex_val(input logic [7:0] b);
        if (b >= "0" && b <= "9") return 4'(b - 8'h30);
        if (b >= "A" && b <= "F") return 4'(b - 8'h37);
        return 4'(b - 8'h57);
    endfunction

    function automatic logic [7:0] to_hex(input logic [3:0] n, input bit lower);
        if (n < 10) return 8'h30 + 8'(n);
        return (lower ? 8'h57 : 8'h37) + 8'(n);
    endfunction

    function automatic logic [VEC_W-1:0] exp_vec();
        return {m_ready, ADDR_W'(m_len), CNT_W'(m_cks), CNT_W'(m_frm), CNT_W'(m_ovf), CNT_W'(m_drp)};
    endfunction

    function automatic logic [7:0] exp_rd(input int a);
        return (m_ready && a < m_len) ? m_pub[a] : 8'h00;
    endfunction

    task automatic model_reset();
        m_active = 0; m_star = 0; m_ready = 0;
        m_cur.delete(); m_tail.delete(); m_pub.delete();
        m_len = 0; m_cks = 0; m_frm = 0; m_ovf = 0; m_drp = 0;
    endtask

    task automatic model_byte(input logic [7:0] b, input bit ack);
        logic [7:0] x;
        bit ok;
        int k;
        if (ack) m_ready = 0;
        if (b == "$") begin
            m_active = 1; m_star = 0; m_cur.delete(); m_tail.delete();
        end else if (m_active && !m_star) begin
            if (b == "*") m_star = 1;
            else if (b == 8'h0D || b == 8'h0A) begin m_frm = sat(m_frm); m_active = 0; end
            else if (m_cur.size() == MAX_LEN) begin m_ovf = sat(m_ovf); m_active = 0; end
            else m_cur.push_back(b);
        end else if (m_active) begin
            m_tail.push_back(b);
            k  = m_tail.size();
            ok = (k <= 2) ? is_hex(b) : (k == 3) ? (b == 8'h0D) : (b == 8'h0A);
            if (!ok) begin
                m_frm = sat(m_frm); m_active = 0;
            end else if (k == 4) begin
                x = 8'h00;
                foreach (m_cur[i]) x ^= m_cur[i];
                if ({hex_val(m_tail[0]), hex_val(m_tail[1])} != x) m_cks = sat(m_cks);
                else if (m_ready) m_drp = sat(m_drp);
                else begin m_pub = m_cur; m_len = m_cur.size(); m_ready = 1; end
                m_active = 0;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit ack);
        rx_data = b; rx_valid = 1'b1; sent_ack = ack;
        @(posedge clk);
        model_byte(b, ack);
        #1;
        rx_valid = 1'b0; sent_ack = 1'b0;
    endtask

    task automatic send_str(input string s, input bit ack_last);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], ack_last && (i == s.len() - 1));
    endtask

    task automatic send_ack();
        sent_ack = 1'b1;
        @(posedge clk);
        m_ready = 0;
        #1;
        sent_ack = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        model_reset();
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (act !== {VEC_W{1'b0}}) begin
            failures++; $display("FAIL reset_status actual=%h required=%h", act, {VEC_W{1'b0}});
        end
        checks++;
        if (rd_data !== 8'h00) begin
            failures++; $display("FAIL reset_rd_data actual=%h required=00", rd_data);
        end
    endtask

    task automatic test_basic();
        send_str("$AB*03\015\012", 1'b0);
        checks++;
        if (sent_ready !== 1'b1 || sent_len !== 7'd2 || act !== exp_vec()) begin
            failures++; $display("FAIL basic_status actual=%h required=%h", act, exp_vec());
        end
        for (int a = 0; a < 3; a++) begin
            rd_addr = ADDR_W'(a);
            @(posedge clk); #1;
            checks++;
            if (rd_data !== exp_rd(a)) begin
                failures++; $display("FAIL basic_rd addr=%0d actual=%h required=%h", a, rd_data, exp_rd(a));
            end
        end
    endtask

    task automatic test_errors();
        send_ack();
        send_str("$AB*04\015\012", 1'b0);
        checks++;
        if (err_cksum !== 16'd1 || act !== exp_vec()) begin
            failures++; $display("FAIL cksum_error actual=%h required=%h", act, exp_vec());
        end
        send_str("$AB*0G", 1'b0);
        checks++;
        if (err_frame !== 16'd1 || act !== exp_vec()) begin
            failures++; $display("FAIL frame_error actual=%h required=%h", act, exp_vec());
        end
        send_str("$A\015", 1'b0);
        send_str("$AB*03\015X", 1'b0);
        checks++;
        if (act !== exp_vec()) begin
            failures++; $display("FAIL frame_eol actual=%h required=%h", act, exp_vec());
        end
    endtask

    task automatic test_overflow();
        send_byte("$", 1'b0);
        for (int i = 0; i < MAX_LEN + 1; i++) send_byte("A", 1'b0);
        checks++;
        if (err_overflow !== 16'd1 || act !== exp_vec()) begin
            failures++; $display("FAIL overflow actual=%h required=%h", act, exp_vec());
        end
        send_str("$A*41\015\012", 1'b0);
        checks++;
        if (sent_ready !== 1'b1 || sent_len !== 7'd1 || act !== exp_vec()) begin
            failures++; $display("FAIL after_overflow actual=%h required=%h", act, exp_vec());
        end
    endtask

    task automatic test_resync();
        send_ack();
        send_str("$A$AB*03\015\012", 1'b0);
        checks++;
        if (sent_len !== 7'd2 || act !== exp_vec()) begin
            failures++; $display("FAIL resync actual=%h required=%h", act, exp_vec());
        end
    endtask

    task automatic test_zero_len();
        send_ack();
        send_str("$*00\015\012", 1'b0);
        checks++;
        if (sent_ready !== 1'b1 || sent_len !== 7'd0 || act !== exp_vec()) begin
            failures++; $display("FAIL zero_len actual=%h required=%h", act, exp_vec());
        end
        rd_addr = '0;
        @(posedge clk); #1;
        checks++;
        if (rd_data !== 8'h00) begin
            failures++; $display("FAIL zero_len_rd actual=%h required=00", rd_data);
        end
    endtask

    task automatic test_back_to_back();
        send_ack();
        send_str("$AB*03\015\012", 1'b0);
        send_str("$CD*07\015\012", 1'b0);
        checks++;
        if (drop_count !== 16'd1 || act !== exp_vec()) begin
            failures++; $display("FAIL drop actual=%h required=%h", act, exp_vec());
        end
        for (int a = 0; a < 2; a++) begin
            rd_addr = ADDR_W'(a);
            @(posedge clk); #1;
            checks++;
            if (rd_data !== exp_rd(a)) begin
                failures++; $display("FAIL drop_rd addr=%0d actual=%h required=%h", a, rd_data, exp_rd(a));
            end
        end
        send_str("$XY*01\015\012", 1'b1);
        checks++;
        if (sent_ready !== 1'b1 || act !== exp_vec()) begin
            failures++; $display("FAIL ack_with_lf actual=%h required=%h", act, exp_vec());
        end
        for (int a = 0; a < 2; a++) begin
            rd_addr = ADDR_W'(a);
            @(posedge clk); #1;
            checks++;
            if (rd_data !== exp_rd(a)) begin
                failures++; $display("FAIL ack_lf_rd addr=%0d actual=%h required=%h", a, rd_data, exp_rd(a));
            end
        end
    endtask

    task automatic test_reset_mid();
        send_str("$AB*", 1'b0);
        do_reset();
        checks++;
        if (act !== {VEC_W{1'b0}} || rd_data !== 8'h00) begin
            failures++; $display("FAIL reset_mid actual=%h/%h required=0", act, rd_data);
        end
        send_str("\015\012", 1'b0);
        checks++;
        if (act !== exp_vec()) begin
            failures++; $display("FAIL reset_mid_eol actual=%h required=%h", act, exp_vec());
        end
        send_str("$AB*03\015\012", 1'b0);
        checks++;
        if (sent_ready !== 1'b1 || act !== exp_vec()) begin
            failures++; $display("FAIL reset_mid_pub actual=%h required=%h", act, exp_vec());
        end
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        logic [7:0] b, cs;
        int len, a;
        for (int it = 0; it < 40; it++) begin
            q.delete();
            repeat ($urandom_range(0, 3)) begin
                b = 8'($urandom_range(0, 255));
                if (b == "$") b = "#";
                q.push_back(b);
            end
            len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(MAX_LEN - 1, MAX_LEN + 2))
                                              : int'($urandom_range(0, 20));
            q.push_back("$");
            cs = 8'h00;
            for (int i = 0; i < len; i++) begin
                do b = 8'($urandom_range(32, 126)); while (b == "$" || b == "*");
                q.push_back(b);
                cs ^= b;
            end
            if ($urandom_range(0, 4) == 0) cs ^= 8'(1 << $urandom_range(0, 7));
            q.push_back("*");
            q.push_back(to_hex(cs[7:4], 1'($urandom_range(0, 1))));
            q.push_back(to_hex(cs[3:0], 1'($urandom_range(0, 1))));
            q.push_back(8'h0D);
            q.push_back(8'h0A);
            if ($urandom_range(0, 9) == 0) q[q.size() - 1 - $urandom_range(0, 3)] = 8'($urandom_range(0, 127));
            if ($urandom_range(0, 2) == 0) send_ack();
            for (int i = 0; i < q.size(); i++)
                send_byte(q[i], (i == q.size() - 1) && ($urandom_range(0, 2) == 0));
            checks++;
            if (act !== exp_vec()) begin
                failures++; $display("FAIL random_status it=%0d actual=%h required=%h", it, act, exp_vec());
            end
            repeat (3) begin
                a = int'($urandom_range(0, 25));
                rd_addr = ADDR_W'(a);
                @(posedge clk); #1;
                checks++;
                if (rd_data !== exp_rd(a)) begin
                    failures++; $display("FAIL random_rd it=%0d addr=%0d actual=%h required=%h", it, a, rd_data, exp_rd(a));
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; sent_ack = 1'b0; rd_addr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_errors();
        test_overflow();
        test_resync();
        test_zero_len();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
